mem_boot_ctrl: RTL and testbench

- Synthesizable boot sequencer placed between the top level and the CPU.
- Performs four steps in order:
  - zero-clears data memory;
  - streams a program image into instruction memory over a valid/ready port;
  - releases the CPU's active-low reset;
  - runs the CPU for a bounded cycle count or until the CPU halts.
- Generalises the bench-only init/run/finish flow into parametrised hardware with load handshake, overflow detection and halt/timeout termination.

---
 rtl/mem_boot_pkg.sv | 16 +
 rtl/mem_boot_ctrl_cnt.sv | 41 ++++
 rtl/mem_boot_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mem_boot_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_boot_pkg.sv
// mem_boot_pkg: state encoding and default widths shared by the boot sequencer.
// Optional checksum output is enabled with BOOT_CHECKSUM_EN (see mem_boot_ctrl).
package mem_boot_pkg;

    localparam int DATA_W  = 32;
    localparam int DMEM_AW = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_boot_ctrl_cnt.sv
// boot_addr_cnt: clearable, loadable word-address counter.
// tc_o flags the last address of the memory being walked.
module boot_addr_cnt #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = &cnt_q;

endmodule

// File: rtl/mem_boot_ctrl.sv
// mem_boot_ctrl: clears dmem, streams the image into imem, then runs the CPU.
// Define BOOT_CHECKSUM_EN to add an XOR checksum of the loaded image.
module mem_boot_ctrl #(
    parameter int DATA_W     = mem_boot_pkg::DATA_W,
    parameter int IMEM_AW    = 10,
    parameter int DMEM_AW    = mem_boot_pkg::DMEM_AW,
    parameter int RUN_W      = 16,
    parameter int RUN_CYCLES = 400
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               load_valid,
    input  logic [DATA_W-1:0]  load_data,
    input  logic               load_last,
    output logic               load_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [DATA_W-1:0]  imem_wdata,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               cpu_halt,
    output logic               cpu_reset,
    output logic               busy,
    output logic               done,
    output logic               load_ovf,
    output logic               timeout,
    output logic [RUN_W-1:0]   run_count
`ifdef BOOT_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]  checksum
`endif
);

    import mem_boot_pkg::*;

    localparam logic [RUN_W-1:0] RUN_LIM =
        RUN_W'((RUN_CYCLES == 0) ? 0 : RUN_CYCLES - 1);

    state_t             state_q;
    logic               load_ready_q;
    logic               imem_we_q;
    logic [IMEM_AW-1:0] imem_addr_q;
    logic [DATA_W-1:0]  imem_wdata_q;
    logic               dmem_we_q;
    logic               cpu_reset_q;
    logic               busy_q;
    logic               done_q;
    logic               load_ovf_q;
    logic               timeout_q;
    logic [RUN_W-1:0]   run_count_q;
    logic [RUN_W-1:0]   run_count_d;

    logic [DMEM_AW-1:0] d_cnt;
    logic               d_tc;
    logic [IMEM_AW-1:0] i_cnt;
    logic               i_tc;
    logic               boot;
    logic               xfer;
    logic               d_inc;

    assign boot  = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign xfer  = (state_q == ST_LOAD) && load_valid && load_ready_q;
    assign d_inc = (state_q == ST_CLEAR) && !d_tc;
    assign run_count_d = (&run_count_q) ? run_count_q
                                        : run_count_q + 1'b1;

    boot_addr_cnt #(.W(DMEM_AW)) u_dcnt (
        .clock    (clock),
        .reset    (reset),
        .clr_i    (boot),
        .ld_i     (1'b0),
        .ld_val_i ('0),
        .inc_i    (d_inc),
        .cnt_o    (d_cnt),
        .tc_o     (d_tc)
    );

    boot_addr_cnt #(.W(IMEM_AW)) u_icnt (
        .clock    (clock),
        .reset    (reset),
        .clr_i    (boot),
        .ld_i     (1'b0),
        .ld_val_i ('0),
        .inc_i    (xfer),
        .cnt_o    (i_cnt),
        .tc_o     (i_tc)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            load_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            dmem_we_q    <= 1'b0;
            cpu_reset_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ovf_q   <= 1'b0;
            timeout_q    <= 1'b0;
            run_count_q  <= '0;
        end else begin
            dmem_we_q <= 1'b0;
            imem_we_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_CLEAR;
                        dmem_we_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        run_count_q <= '0;
                        load_ovf_q  <= 1'b0;
                        timeout_q   <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (d_tc) begin
                        state_q      <= ST_LOAD;
                        load_ready_q <= 1'b1;
                    end else begin
                        dmem_we_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= i_cnt;
                        imem_wdata_q <= load_data;
                        // Full imem ends the load even without load_last.
                        if (load_last || i_tc) begin
                            state_q      <= ST_RUN;
                            load_ready_q <= 1'b0;
                            cpu_reset_q  <= 1'b1;
                            load_ovf_q   <= !load_last;
                        end
                    end
                end
                ST_RUN: begin
                    run_count_q <= run_count_d;
                    if (cpu_halt ||
                        (RUN_CYCLES != 0 && run_count_q == RUN_LIM)) begin
                        state_q     <= ST_DONE;
                        cpu_reset_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        timeout_q   <= !cpu_halt;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef BOOT_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clock) begin
        if (!reset || boot) begin
            csum_q <= '0;
        end else if (xfer) begin
            csum_q <= csum_q ^ load_data;
        end
    end

    assign checksum = csum_q;
`endif

    assign load_ready = load_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = d_cnt;
    assign dmem_wdata = '0;
    assign cpu_reset  = cpu_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ovf   = load_ovf_q;
    assign timeout    = timeout_q;
    assign run_count  = run_count_q;

endmodule

// File: tb/tb_mem_boot_ctrl.sv
// tb_mem_boot_ctrl: scoreboard bench for mem_boot_ctrl with a tiny memory map.
// Build with BOOT_CHECKSUM_EN defined to also check the image checksum.
module tb_mem_boot_ctrl;

    localparam int DW  = 32;
    localparam int IAW = 2;
    localparam int DAW = 3;
    localparam int RW  = 16;
    localparam int RC  = 5;

    logic           clock;
    logic           reset;
    logic           start;
    logic           load_valid;
    logic [DW-1:0]  load_data;
    logic           load_last;
    logic           load_ready;
    logic           imem_we;
    logic [IAW-1:0] imem_addr;
    logic [DW-1:0]  imem_wdata;
    logic           dmem_we;
    logic [DAW-1:0] dmem_addr;
    logic [DW-1:0]  dmem_wdata;
    logic           cpu_halt;
    logic           cpu_reset;
    logic           busy;
    logic           done;
    logic           load_ovf;
    logic           timeout;
    logic [RW-1:0]  run_count;
`ifdef BOOT_CHECKSUM_EN
    logic [DW-1:0]  checksum;
`endif

    int vecs = 0;
    int errs = 0;

    logic [DW-1:0]      img [8];
    logic [IAW+DW-1:0]  iq [$];
    logic [92:0]        outs;

    assign outs = {load_ready, imem_we, imem_addr, imem_wdata, dmem_we,
                   dmem_addr, dmem_wdata, cpu_reset, busy, done,
                   load_ovf, timeout, run_count};

    mem_boot_ctrl #(
        .DATA_W     (DW),
        .IMEM_AW    (IAW),
        .DMEM_AW    (DAW),
        .RUN_W      (RW),
        .RUN_CYCLES (RC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .cpu_halt   (cpu_halt),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .load_ovf   (load_ovf),
        .timeout    (timeout),
        .run_count  (run_count)
`ifdef BOOT_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        reset      = 1'b0;
        start      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        cpu_halt   = 1'b0;
        repeat (3) @(negedge clock);
        vecs++;
        if (outs !== '0) begin
            errs++;
            $display("FAIL reset_outs: got %h expected 0", outs);
        end
`ifdef BOOT_CHECKSUM_EN
        vecs++;
        if (checksum !== '0) begin
            errs++;
            $display("FAIL reset_csum: got %h expected 0", checksum);
        end
`endif
        reset = 1'b1;
        @(negedge clock);
    endtask

    // Start a boot and expect 8 back-to-back zero writes, then LOAD.
    task automatic test_clear();
        logic [DAW-1:0] dq [$];
        logic [DAW-1:0] e;
        for (int i = 0; i < 8; i++) dq.push_back(DAW'(i));
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        vecs++;
        if ({busy, done, timeout, load_ovf, run_count} !== {4'b1000, 16'd0}) begin
            errs++;
            $display("FAIL clear_entry: got %b/%b/%b/%b/%0d expected 1/0/0/0/0",
                     busy, done, timeout, load_ovf, run_count);
        end
        while (dq.size() != 0) begin
            e = dq.pop_front();
            vecs++;
            if (dmem_we !== 1'b1 || dmem_addr !== e || dmem_wdata !== '0 ||
                cpu_reset !== 1'b0 || load_ready !== 1'b0) begin
                errs++;
                $display("FAIL clear_wr: got we=%b a=%0d d=%h cr=%b lr=%b expected we=1 a=%0d d=0 cr=0 lr=0",
                         dmem_we, dmem_addr, dmem_wdata, cpu_reset, load_ready, e);
            end
            @(negedge clock);
        end
        vecs++;
        if ({dmem_we, load_ready, cpu_reset, busy} !== 4'b0101) begin
            errs++;
            $display("FAIL clear_end: got we=%b lr=%b cr=%b busy=%b expected 0/1/0/1",
                     dmem_we, load_ready, cpu_reset, busy);
        end
    endtask

    // Stream img[0..n-1]; optional stall with load_last raised but no valid.
    task automatic load_image(input int n, input bit use_last,
                              input int gap_at, input int gap_len,
                              output int acc);
        int i;
        int g;
        int cyc;
        logic [IAW+DW-1:0] e;
        i   = 0;
        g   = 0;
        acc = 0;
        cyc = 0;
        while (cyc < 40) begin
            if (imem_we === 1'b1) begin
                vecs++;
                if (iq.size() == 0) begin
                    errs++;
                    $display("FAIL imem_unexp: got write a=%0d d=%h expected none",
                             imem_addr, imem_wdata);
                end else begin
                    e = iq.pop_front();
                    if ({imem_addr, imem_wdata} !== e) begin
                        errs++;
                        $display("FAIL imem_wr: got a=%0d d=%h expected a=%0d d=%h",
                                 imem_addr, imem_wdata, e[IAW+DW-1:DW], e[DW-1:0]);
                    end
                end
            end
            if (iq.size() == 0 &&
                (i == n || (acc > 0 && load_ready !== 1'b1))) break;
            if (i < n && !(i == gap_at && g < gap_len)) begin
                load_valid = 1'b1;
                load_data  = img[i];
                load_last  = use_last && (i == n - 1);
                if (load_ready === 1'b1) begin
                    iq.push_back({IAW'(acc), img[i]});
                    acc++;
                    i++;
                end
            end else begin
                load_valid = 1'b0;
                load_last  = 1'b1;
                g++;
            end
            @(negedge clock);
            cyc++;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        vecs++;
        if (cyc >= 40) begin
            errs++;
            $display("FAIL load_bound: got %0d cycles expected < 40", cyc);
        end
    endtask

    // From RUN cycle 0, run until cpu_reset drops; start pulses are ignored.
    task automatic run_phase(input int halt_at, input int exp_n,
                             input bit exp_to, input string nm);
        int n;
        n = 0;
        while (cpu_reset === 1'b1 && n < 20) begin
            cpu_halt = (n == halt_at);
            start    = (n == 1);
            @(negedge clock);
            n++;
        end
        cpu_halt = 1'b0;
        start    = 1'b0;
        vecs++;
        if (n != exp_n) begin
            errs++;
            $display("FAIL %s_len: got %0d run cycles expected %0d", nm, n, exp_n);
        end
        vecs++;
        if ({done, busy, cpu_reset, timeout} !== {3'b100, exp_to} ||
            run_count !== RW'(exp_n)) begin
            errs++;
            $display("FAIL %s_done: got dn=%b bz=%b cr=%b to=%b rc=%0d expected 1/0/0/%b/%0d",
                     nm, done, busy, cpu_reset, timeout, run_count, exp_to, exp_n);
        end
    endtask

    task automatic test_load();
        int acc;
        img[0] = 32'h2010_0009;
        img[1] = 32'h0000_0000;
        img[2] = 32'hAC10_0004;
        load_image(3, 1'b1, 1, 2, acc);
        vecs++;
        if (acc != 3 || {cpu_reset, busy, load_ready, load_ovf} !== 4'b1100 ||
            run_count !== '0) begin
            errs++;
            $display("FAIL load_run: got acc=%0d cr=%b bz=%b lr=%b ovf=%b rc=%0d expected 3/1/1/0/0/0",
                     acc, cpu_reset, busy, load_ready, load_ovf, run_count);
        end
    endtask

    task automatic test_timeout();
        run_phase(-1, 5, 1'b1, "timeout");
        repeat (2) @(negedge clock);
        vecs++;
        if (run_count !== 16'd5 || timeout !== 1'b1 || done !== 1'b1) begin
            errs++;
            $display("FAIL done_hold: got rc=%0d to=%b dn=%b expected 5/1/1",
                     run_count, timeout, done);
        end
    endtask

    task automatic test_halt();
        int acc;
        test_clear();
        img[0] = 32'h1234_5678;
        load_image(1, 1'b1, -1, 0, acc);
        vecs++;
        if (acc != 1 || cpu_reset !== 1'b1) begin
            errs++;
            $display("FAIL one_word: got acc=%0d cr=%b expected 1/1", acc, cpu_reset);
        end
        run_phase(2, 3, 1'b0, "halt_early");
        test_clear();
        img[0] = 32'hDEAD_BEEF;
        img[1] = 32'h0BAD_F00D;
        img[2] = 32'h5555_AAAA;
        load_image(3, 1'b1, -1, 0, acc);
        run_phase(4, 5, 1'b0, "halt_limit");
    endtask

    task automatic test_overflow();
        int acc;
        test_clear();
        for (int i = 0; i < 6; i++) img[i] = 32'hA000_0000 + 32'(i);
        load_image(6, 1'b0, -1, 0, acc);
        vecs++;
        if (acc != 4 || load_ovf !== 1'b1 || load_ready !== 1'b0 ||
            cpu_reset !== 1'b1) begin
            errs++;
            $display("FAIL ovf: got acc=%0d ovf=%b lr=%b cr=%b expected 4/1/0/1",
                     acc, load_ovf, load_ready, cpu_reset);
        end
        run_phase(-1, 5, 1'b1, "ovf_run");
        vecs++;
        if (load_ovf !== 1'b1) begin
            errs++;
            $display("FAIL ovf_hold: got %b expected 1", load_ovf);
        end
        test_clear();
        load_image(4, 1'b1, -1, 0, acc);
        vecs++;
        if (acc != 4 || load_ovf !== 1'b0 || cpu_reset !== 1'b1) begin
            errs++;
            $display("FAIL exact_fit: got acc=%0d ovf=%b cr=%b expected 4/0/1",
                     acc, load_ovf, cpu_reset);
        end
        run_phase(-1, 5, 1'b1, "fit_run");
    endtask

    task automatic test_reset_mid_load();
        int acc;
        test_clear();
        img[0] = 32'h0F0F_0F0F;
        img[1] = 32'hFFFF_0000;
        load_image(2, 1'b0, -1, 0, acc);
        vecs++;
        if (acc != 2 || load_ready !== 1'b1 || cpu_reset !== 1'b0) begin
            errs++;
            $display("FAIL mid_load: got acc=%0d lr=%b cr=%b expected 2/1/0",
                     acc, load_ready, cpu_reset);
        end
`ifdef BOOT_CHECKSUM_EN
        vecs++;
        if (checksum !== (img[0] ^ img[1]) || checksum !== 32'hF0F0_0F0F) begin
            errs++;
            $display("FAIL csum: got %h expected f0f00f0f", checksum);
        end
`endif
        reset = 1'b0;
        @(negedge clock);
        vecs++;
        if (outs !== '0) begin
            errs++;
            $display("FAIL mid_reset: got %h expected 0", outs);
        end
`ifdef BOOT_CHECKSUM_EN
        vecs++;
        if (checksum !== '0) begin
            errs++;
            $display("FAIL mid_reset_csum: got %h expected 0", checksum);
        end
`endif
        reset = 1'b1;
        @(negedge clock);
        test_clear();
    endtask

    initial begin
        test_reset();
        test_clear();
        test_load();
        test_timeout();
        test_halt();
        test_overflow();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
